// File: rtl/param_load_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : param_load_sequencer_pkg
// Brief    : Shared FSM encoding and default sizing for the parameter loader.
// Revision : 1.0 - initial release
// ============================================================================
package param_load_sequencer_pkg;

    localparam int c_DEF_NUM_PARAMS = 6002;
    localparam int c_DEF_DATA_W     = 32;
    localparam int c_DEF_RD_LAT     = 2;
    localparam int c_DEF_ADDR_W     = $clog2(c_DEF_NUM_PARAMS);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // Two slots beyond the read latency let the stream run at one word per cycle.
    function automatic int fifo_depth(input int rd_lat);
        return rd_lat + 2;
    endfunction

endpackage : param_load_sequencer_pkg
`default_nettype wire

// File: rtl/param_return_fifo.sv
`default_nettype none
// ============================================================================
// Module   : param_return_fifo
// Brief    : First-word-fall-through buffer holding {idx,data} returned by BRAM.
// Revision : 1.0 - initial release
// ============================================================================
module param_return_fifo
    import param_load_sequencer_pkg::*;
#(
    parameter int DEPTH = fifo_depth(c_DEF_RD_LAT),
    parameter int WIDTH = c_DEF_ADDR_W + c_DEF_DATA_W,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_pop_data,
    output logic             o_full,
    output logic             o_empty,
    output logic [CNT_W-1:0] o_count
);

    localparam int              PTR_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] c_LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] c_DEPTH    = CNT_W'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full     = (r_count == c_DEPTH);
    assign o_empty    = (r_count == '0);
    assign o_count    = r_count;
    assign w_do_pop   = i_pop && !o_empty;
    assign w_do_push  = i_push && (!o_full || w_do_pop);
    // Head is gated so the data port reads zero whenever nothing is held.
    assign o_pop_data = o_empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= (r_wr_ptr == c_LAST_PTR) ? '0 : r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= (r_rd_ptr == c_LAST_PTR) ? '0 : r_rd_ptr + PTR_W'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

endmodule : param_return_fifo
`default_nettype wire

// File: rtl/param_load_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : param_load_sequencer
// Brief    : Streams the parameter image out of the weight BRAM as an ordered,
//            index-tagged valid/ready stream with back-pressure.
// Revision : 1.0 - initial release
// ============================================================================
module param_load_sequencer
    import param_load_sequencer_pkg::*;
#(
    parameter int NUM_PARAMS = c_DEF_NUM_PARAMS,
    parameter int ADDR_W     = c_DEF_ADDR_W,
    parameter int DATA_W     = c_DEF_DATA_W,
    parameter int RD_LAT     = c_DEF_RD_LAT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              bram_en,
    output logic [ADDR_W-1:0] bram_addr,
    input  logic [DATA_W-1:0] bram_dout,
    output logic              param_valid,
    input  logic              param_ready,
    output logic [DATA_W-1:0] param_data,
    output logic [ADDR_W-1:0] param_idx,
    output logic              busy,
    output logic              done
);

    localparam int FIFO_DEPTH = fifo_depth(RD_LAT);
    localparam int OUT_W      = $clog2(FIFO_DEPTH + 1);

    localparam logic [ADDR_W-1:0] c_LAST_ADDR  = ADDR_W'(NUM_PARAMS - 1);
    localparam logic [OUT_W-1:0]  c_FIFO_DEPTH = OUT_W'(FIFO_DEPTH);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   r_addr;
    logic [ADDR_W-1:0]   r_wr_idx;
    logic [RD_LAT-1:0]   r_pipe;
    logic [OUT_W-1:0]    w_in_flight;
    logic [OUT_W-1:0]    w_outstanding;
    logic [OUT_W-1:0]    w_fifo_count;
    logic                w_fifo_full;
    logic                w_fifo_empty;
    logic                w_issue;
    logic                w_start_accept;
    logic                w_ret_valid;
    logic                w_handshake;

    assign w_start_accept = (r_state == S_IDLE) && start;
    assign w_ret_valid    = r_pipe[RD_LAT-1];
    assign w_handshake    = param_valid && param_ready;

    // Reads still in the BRAM pipe count against buffer space they will need.
    always_comb begin
        w_in_flight = '0;
        for (int k = 0; k < RD_LAT; k++) begin
            w_in_flight = w_in_flight + OUT_W'(r_pipe[k]);
        end
        w_outstanding = w_in_flight + w_fifo_count;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_FETCH;
                end
            end
            S_FETCH: begin
                w_issue = (w_outstanding < c_FIFO_DEPTH) && !w_fifo_full;
                if (w_issue && (r_addr == c_LAST_ADDR)) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_handshake && (param_idx == c_LAST_ADDR)) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_addr   <= '0;
            r_wr_idx <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_start_accept) begin
                r_addr <= '0;
            end else if (w_issue && (r_addr != c_LAST_ADDR)) begin
                r_addr <= r_addr + ADDR_W'(1);
            end
            if (w_start_accept) begin
                r_wr_idx <= '0;
            end else if (w_ret_valid) begin
                r_wr_idx <= r_wr_idx + ADDR_W'(1);
            end
        end
    end

    if (RD_LAT == 1) begin : g_pipe_single
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_pipe <= '0;
            end else begin
                r_pipe <= w_issue;
            end
        end
    end else begin : g_pipe_multi
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_pipe <= '0;
            end else begin
                r_pipe <= {r_pipe[RD_LAT-2:0], w_issue};
            end
        end
    end

    param_return_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ADDR_W + DATA_W),
        .CNT_W (OUT_W)
    ) u_return_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (w_ret_valid),
        .i_push_data ({r_wr_idx, bram_dout}),
        .i_pop       (param_ready),
        .o_pop_data  ({param_idx, param_data}),
        .o_full      (w_fifo_full),
        .o_empty     (w_fifo_empty),
        .o_count     (w_fifo_count)
    );

    assign bram_en     = w_issue;
    assign bram_addr   = r_addr;
    assign param_valid = !w_fifo_empty;
    assign busy        = (r_state == S_FETCH) || (r_state == S_DRAIN);
    assign done        = (r_state == S_DONE);

endmodule : param_load_sequencer
`default_nettype wire

// File: tb/tb_param_load_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_param_load_sequencer
// Brief    : Scoreboard bench for the parameter loader (8-word and 1-word images).
// Revision : 1.0 - initial release
// ============================================================================
module tb_param_load_sequencer;

    localparam int AW  = 13;
    localparam int DW  = 32;
    localparam int LAT = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          start_a, ready_a, en_a, valid_a, busy_a, done_a;
    logic [AW-1:0] addr_a, idx_a;
    logic [DW-1:0] dout_a, data_a;
    logic          start_b, ready_b, en_b, valid_b, busy_b, done_b;
    logic [AW-1:0] addr_b, idx_b;
    logic [DW-1:0] dout_b, data_b;

    int n_checks = 0;
    int n_fail   = 0;

    param_load_sequencer #(.NUM_PARAMS(8), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(LAT)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .bram_en(en_a), .bram_addr(addr_a),
        .bram_dout(dout_a), .param_valid(valid_a), .param_ready(ready_a), .param_data(data_a),
        .param_idx(idx_a), .busy(busy_a), .done(done_a));

    param_load_sequencer #(.NUM_PARAMS(1), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(LAT)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .bram_en(en_b), .bram_addr(addr_b),
        .bram_dout(dout_b), .param_valid(valid_b), .param_ready(ready_b), .param_data(data_b),
        .param_idx(idx_b), .busy(busy_b), .done(done_b));

    // BRAM models: dout = addr*3+1, two-cycle read latency.
    logic [DW-1:0] ba_s1, ba_s2, bb_s1, bb_s2;
    always @(posedge clk) begin
        if (en_a) ba_s1 <= DW'(addr_a) * 3 + 1;
        ba_s2 <= ba_s1;
        if (en_b) bb_s1 <= DW'(addr_b) * 3 + 1;
        bb_s2 <= bb_s1;
    end
    assign dout_a = ba_s2;
    assign dout_b = bb_s2;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] outs(input int d);
        if (d == 0) return 64'({en_a, addr_a, valid_a, data_a, idx_a, busy_a, done_a});
        return 64'({en_b, addr_b, valid_b, data_b, idx_b, busy_b, done_b});
    endfunction

    // Monitor per DUT: pops the scoreboard on each handshake and checks protocol rules.
    for (genvar d = 0; d < 2; d++) begin : g_mon
        localparam logic [AW-1:0] LAST_IDX = (d == 0) ? AW'(7) : AW'(0);
        logic [AW+DW-1:0] q [$];
        logic             v, r, dn, en;
        logic [AW+DW-1:0] word;
        assign v    = (d == 0) ? valid_a : valid_b;
        assign r    = (d == 0) ? ready_a : ready_b;
        assign dn   = (d == 0) ? done_a  : done_b;
        assign en   = (d == 0) ? en_a    : en_b;
        assign word = (d == 0) ? {idx_a, data_a} : {idx_b, data_b};

        initial begin
            logic             stall_prev;
            logic             last_prev;
            logic [AW+DW-1:0] held;
            logic [AW+DW-1:0] exp_w;
            int               outst;
            stall_prev = 1'b0;
            last_prev  = 1'b0;
            held       = '0;
            outst      = 0;
            forever begin
                @(negedge clk);
                if (!rst_n) begin
                    stall_prev = 1'b0;
                    last_prev  = 1'b0;
                    outst      = 0;
                end else begin
                    if (stall_prev) begin
                        check($sformatf("hold_valid_d%0d", d), 64'(v), 64'd1);
                        check($sformatf("hold_word_d%0d", d), 64'(word), 64'(held));
                    end
                    if (dn) begin
                        check($sformatf("done_after_last_d%0d", d), 64'(last_prev), 64'd1);
                        check($sformatf("all_words_seen_d%0d", d), 64'(q.size()), 64'd0);
                    end
                    outst = outst + int'(en) - int'(v && r);
                    check($sformatf("outstanding_le_4_d%0d", d), 64'(outst <= 4), 64'd1);
                    if (v && r) begin
                        if (q.size() == 0) begin
                            n_checks++;
                            n_fail++;
                            $display("FAIL unexpected_word_d%0d: got idx %0d data %0d, expected no word",
                                     d, word[AW+DW-1:DW], word[DW-1:0]);
                        end else begin
                            exp_w = q.pop_front();
                            check($sformatf("word_order_d%0d", d), 64'(word), 64'(exp_w));
                        end
                    end
                    stall_prev = v && !r;
                    held       = word;
                    last_prev  = v && r && (word[AW+DW-1:DW] == LAST_IDX);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run(input int d);
        int n;
        n = (d == 0) ? 8 : 1;
        for (int i = 0; i < n; i++) begin
            if (d == 0) g_mon[0].q.push_back({AW'(i), DW'(i * 3 + 1)});
            else        g_mon[1].q.push_back({AW'(i), DW'(i * 3 + 1)});
        end
        if (d == 0) start_a = 1'b1;
        else        start_b = 1'b1;
    endtask

    task automatic run_until_done(input int d, input int bound, input bit rnd);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < bound && !seen; i++) begin
            if (rnd) begin
                if (d == 0) ready_a = 1'($urandom_range(0, 1));
                else        ready_b = 1'($urandom_range(0, 1));
            end
            #3;
            seen = (d == 0) ? done_a : done_b;
            tick();
            start_a = 1'b0;
            start_b = 1'b0;
        end
        check($sformatf("done_within_bound_d%0d", d), 64'(seen), 64'd1);
    endtask

    task automatic sample(input int d, input string tag, input int c, input bit en_e, input int addr_e,
                          input bit v_e, input int ix_e, input bit busy_e, input bit done_e);
        logic en, v, bz, dn;
        logic [AW-1:0] ad, ix;
        logic [DW-1:0] dt;
        if (d == 0) begin
            en = en_a; v = valid_a; bz = busy_a; dn = done_a; ad = addr_a; ix = idx_a; dt = data_a;
        end else begin
            en = en_b; v = valid_b; bz = busy_b; dn = done_b; ad = addr_b; ix = idx_b; dt = data_b;
        end
        check($sformatf("%s_en_valid_busy_done_c%0d", tag, c), 64'({en, v, bz, dn}),
              64'({en_e, v_e, busy_e, done_e}));
        if (en_e) check($sformatf("%s_addr_c%0d", tag, c), 64'(ad), 64'(addr_e));
        if (v_e) begin
            check($sformatf("%s_idx_c%0d", tag, c), 64'(ix), 64'(ix_e));
            check($sformatf("%s_data_c%0d", tag, c), 64'(dt), 64'(ix_e * 3 + 1));
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected end of test");
        $fatal(1);
    end

    initial begin
        int n_en, max_addr, n_done;
        rst_n = 1'b0;
        start_a = 1'b0; ready_a = 1'b0; start_b = 1'b0; ready_b = 1'b0;

        // 1: reset with random inputs, start during reset must be ignored
        for (int i = 0; i < 5; i++) begin
            tick();
            start_a = (i == 4) ? 1'b1 : 1'($urandom);
            ready_a = 1'($urandom);
            start_b = (i == 4) ? 1'b1 : 1'($urandom);
            ready_b = 1'($urandom);
            #3;
            check($sformatf("t1_reset_outputs_a_%0d", i), outs(0), 64'd0);
            check($sformatf("t1_reset_outputs_b_%0d", i), outs(1), 64'd0);
        end
        tick();
        start_a = 1'b0; start_b = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            #3;
            check($sformatf("t1_idle_after_release_%0d", i), 64'({en_a, busy_a, en_b, busy_b}), 64'd0);
        end
        tick();

        // 2: full-rate run with ready held high
        ready_a = 1'b1;
        start_run(0);
        for (int c = 0; c < 14; c++) begin
            #3;
            sample(0, "t2", c, c >= 1 && c <= 8, c - 1, c >= 4 && c <= 11, c - 4,
                   c >= 1 && c <= 11, c == 12);
            tick();
            start_a = 1'b0;
        end

        // 3: consumer stalls in cycles 3..12
        n_en = 0; max_addr = 0;
        start_run(0);
        for (int c = 0; c <= 12; c++) begin
            ready_a = !(c >= 3);
            #3;
            if (en_a) begin
                n_en++;
                if (int'(addr_a) > max_addr) max_addr = int'(addr_a);
            end
            tick();
            start_a = 1'b0;
        end
        check("t3_issues_during_stall", 64'(n_en), 64'd4);
        check("t3_max_addr_during_stall", 64'(max_addr), 64'd3);
        ready_a = 1'b1;
        run_until_done(0, 60, 1'b0);

        // 4: starts in FETCH and DONE ignored, start in IDLE accepted
        n_done = 0;
        for (int c = 0; c <= 26; c++) begin
            if (c == 0 || c == 13) start_run(0);
            else if (c == 5 || c == 12) start_a = 1'b1;
            #3;
            if (done_a) n_done++;
            if (c == 12) check("t4_done_first_run", 64'(done_a), 64'd1);
            if (c == 13) check("t4_idle_between_runs", 64'({busy_a, done_a, en_a}), 64'd0);
            if (c == 14) check("t4_second_run_first_issue", 64'({en_a, addr_a}), 64'({1'b1, AW'(0)}));
            if (c == 25) check("t4_done_second_run", 64'(done_a), 64'd1);
            tick();
            start_a = 1'b0;
        end
        check("t4_done_pulse_count", 64'(n_done), 64'd2);

        // 5: asynchronous reset mid-run, then a clean restart
        start_run(0);
        for (int c = 0; c < 6; c++) begin
            #3;
            tick();
            start_a = 1'b0;
        end
        #1;
        rst_n = 1'b0;
        #1;
        check("t5_async_reset_outputs", outs(0), 64'd0);
        g_mon[0].q.delete();
        tick();
        rst_n = 1'b1;
        tick();
        start_run(0);
        run_until_done(0, 60, 1'b0);

        // 6: single-word image, then random back-pressure runs on both images
        ready_b = 1'b1;
        start_run(1);
        for (int c = 0; c < 7; c++) begin
            #3;
            sample(1, "t6", c, c == 1, 0, c == 4, 0, c >= 1 && c <= 4, c == 5);
            tick();
            start_b = 1'b0;
        end
        for (int r = 0; r < 400; r++) begin
            start_run(0);
            run_until_done(0, 400, 1'b1);
        end
        ready_a = 1'b1;
        for (int r = 0; r < 600; r++) begin
            start_run(1);
            run_until_done(1, 100, 1'b1);
        end
        tick();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_param_load_sequencer
`default_nettype wire
